// File: rtl/vm_pkg.sv
// vm_pkg: definitions shared by the vending machine's coin path.
//   AMT_W          width of every money amount (10-bit unsigned)
//   COIN_NONE..5   hopper coin codes; COIN_NONE means "no coin"
//   state_t        change_dispenser FSM state encoding
package vm_pkg;

  localparam int AMT_W  = 10;
  localparam int CODE_W = 3;

  localparam logic [CODE_W-1:0] COIN_NONE = 3'd0;
  localparam logic [CODE_W-1:0] COIN_1    = 3'd1;
  localparam logic [CODE_W-1:0] COIN_2    = 3'd2;
  localparam logic [CODE_W-1:0] COIN_3    = 3'd3;
  localparam logic [CODE_W-1:0] COIN_4    = 3'd4;
  localparam logic [CODE_W-1:0] COIN_5    = 3'd5;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    REQ,
    RELEASE,
    DONE,
    FAULT
  } state_t;

endpackage

// File: rtl/coin_select.sv
// coin_select: combinational greedy picker. Returns the highest coin code
// whose value fits in the remaining amount and whose tube is not empty.
//   remain        amount still to pay
//   hopper_empty  bit k-1 set means coin code k is unavailable
//   code          chosen coin code, COIN_NONE when nothing fits
//   found         a coin was chosen
module coin_select
  import vm_pkg::*;
#(
  parameter logic [AMT_W-1:0] COIN_V1 = 10'd5,
  parameter logic [AMT_W-1:0] COIN_V2 = 10'd10,
  parameter logic [AMT_W-1:0] COIN_V3 = 10'd25,
  parameter logic [AMT_W-1:0] COIN_V4 = 10'd50,
  parameter logic [AMT_W-1:0] COIN_V5 = 10'd100
) (
  input  logic [AMT_W-1:0]  remain,
  input  logic [4:0]        hopper_empty,
  output logic [CODE_W-1:0] code,
  output logic              found
);

  // NOTE: every output gets a default before the if-chain so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    code = COIN_NONE;
    if      (!hopper_empty[4] && COIN_V5 <= remain) code = COIN_5;
    else if (!hopper_empty[3] && COIN_V4 <= remain) code = COIN_4;
    else if (!hopper_empty[2] && COIN_V3 <= remain) code = COIN_3;
    else if (!hopper_empty[1] && COIN_V2 <= remain) code = COIN_2;
    else if (!hopper_empty[0] && COIN_V1 <= remain) code = COIN_1;
  end

  assign found = (code != COIN_NONE);

endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: pays a change amount back out through the coin hopper,
// one coin at a time, greedy largest-first, skipping empty tubes.
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_start, i_change   start strobe and amount (sampled together in IDLE)
//   i_hopper_empty      per-code tube empty flags
//   i_coin_ack          4-phase ack from the hopper
//   i_clear             leave FAULT
//   o_busy              high whenever the FSM is not IDLE
//   o_coin_req/type     coin request and its code (0 when no request)
//   o_paid              running total ejected this transaction
//   o_residue, o_short  unpaid remainder and its nonzero flag
//   o_done              one-cycle end-of-payout pulse
//   o_fault             ack timeout, sticky until i_clear
module change_dispenser
  import vm_pkg::*;
#(
  parameter logic [AMT_W-1:0] COIN_V1     = 10'd5,
  parameter logic [AMT_W-1:0] COIN_V2     = 10'd10,
  parameter logic [AMT_W-1:0] COIN_V3     = 10'd25,
  parameter logic [AMT_W-1:0] COIN_V4     = 10'd50,
  parameter logic [AMT_W-1:0] COIN_V5     = 10'd100,
  parameter logic [31:0]      ACK_TIMEOUT = 32'd1000000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [AMT_W-1:0]  i_change,
  input  logic [4:0]        i_hopper_empty,
  input  logic              i_coin_ack,
  input  logic              i_clear,
  output logic              o_busy,
  output logic              o_coin_req,
  output logic [CODE_W-1:0] o_coin_type,
  output logic [AMT_W-1:0]  o_paid,
  output logic [AMT_W-1:0]  o_residue,
  output logic              o_done,
  output logic              o_short,
  output logic              o_fault
);

  state_t              state, state_next;
  logic [AMT_W-1:0]    r_remain;
  logic [CODE_W-1:0]   r_code;
  logic [31:0]         r_wait;
  logic [CODE_W-1:0]   sel_code;
  logic                sel_found;
  logic [AMT_W-1:0]    code_val;
  logic                ack_timeout;

  coin_select #(
    .COIN_V1 (COIN_V1),
    .COIN_V2 (COIN_V2),
    .COIN_V3 (COIN_V3),
    .COIN_V4 (COIN_V4),
    .COIN_V5 (COIN_V5)
  ) u_coin_select (
    .remain       (r_remain),
    .hopper_empty (i_hopper_empty),
    .code         (sel_code),
    .found        (sel_found)
  );

  always_comb begin
    unique case (r_code)
      COIN_1:  code_val = COIN_V1;
      COIN_2:  code_val = COIN_V2;
      COIN_3:  code_val = COIN_V3;
      COIN_4:  code_val = COIN_V4;
      COIN_5:  code_val = COIN_V5;
      default: code_val = '0;
    endcase
  end

  // r_wait counts REQ cycles already spent without an ack, so this is true
  // on the ACK_TIMEOUT-th one.
  assign ack_timeout = (r_wait == ACK_TIMEOUT - 32'd1);

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (i_start) state_next = SELECT;
      SELECT:  state_next = (r_remain != '0 && sel_found) ? REQ : DONE;
      REQ: begin
        if (i_coin_ack)       state_next = RELEASE;
        else if (ack_timeout) state_next = FAULT;
      end
      RELEASE: if (!i_coin_ack) state_next = SELECT;
      DONE:    state_next = IDLE;
      FAULT:   if (i_clear) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from the state being left, so each state's effect
  // is visible one edge after it is evaluated (request rises on the first REQ
  // edge, done pulses in the cycle after DONE).
  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      r_remain    <= '0;
      r_code      <= COIN_NONE;
      r_wait      <= '0;
      o_busy      <= 1'b0;
      o_coin_req  <= 1'b0;
      o_coin_type <= COIN_NONE;
      o_paid      <= '0;
      o_residue   <= '0;
      o_done      <= 1'b0;
      o_short     <= 1'b0;
      o_fault     <= 1'b0;
    end else begin
      state  <= state_next;
      o_busy <= (state_next != IDLE);
      o_done <= 1'b0;
      unique case (state)
        IDLE: if (i_start) begin
          r_remain  <= i_change;
          o_paid    <= '0;
          o_short   <= 1'b0;
          o_residue <= '0;
        end
        SELECT: begin
          r_wait <= '0;
          if (sel_found) r_code <= sel_code;
        end
        REQ: begin
          if (i_coin_ack) begin
            // SELECT only picks coins that fit, so this cannot underflow.
            r_remain    <= r_remain - code_val;
            o_paid      <= o_paid + code_val;
            o_coin_req  <= 1'b0;
            o_coin_type <= COIN_NONE;
          end else if (ack_timeout) begin
            o_fault     <= 1'b1;
            o_coin_req  <= 1'b0;
            o_coin_type <= COIN_NONE;
          end else begin
            r_wait      <= r_wait + 32'd1;
            o_coin_req  <= 1'b1;
            o_coin_type <= r_code;
          end
        end
        DONE: begin
          o_done    <= 1'b1;
          o_residue <= r_remain;
          o_short   <= (r_remain != '0);
        end
        FAULT: if (i_clear) o_fault <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: table-driven payout transactions with a queue of
// expected coin codes consumed by a 1-cycle-ack hopper model, plus
// hand-written ack-timeout and asynchronous-reset sequences.
module tb_change_dispenser;
  import vm_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [AMT_W-1:0]  change;
  logic [4:0]        empty;
  logic              ack;
  logic              clear;
  logic              busy, coin_req, done, short_f, fault;
  logic [CODE_W-1:0] coin_type;
  logic [AMT_W-1:0]  paid, residue;

  int n_checks = 0;
  int n_fail   = 0;

  logic [CODE_W-1:0] sb[$];

  typedef struct {
    logic [AMT_W-1:0]       change;
    logic [4:0]             empty;
    int                     n;
    logic [3:0][CODE_W-1:0] codes;   // codes[0] is paid first
    logic [AMT_W-1:0]       paid;
    logic [AMT_W-1:0]       residue;
    logic                   exp_short;
  } vec_t;

  vec_t vecs[7];

  change_dispenser #(.ACK_TIMEOUT(32'd8)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_start        (start),
    .i_change       (change),
    .i_hopper_empty (empty),
    .i_coin_ack     (ack),
    .i_clear        (clear),
    .o_busy         (busy),
    .o_coin_req     (coin_req),
    .o_coin_type    (coin_type),
    .o_paid         (paid),
    .o_residue      (residue),
    .o_done         (done),
    .o_short        (short_f),
    .o_fault        (fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Starts one payout and plays the hopper until o_done or a cycle budget runs out.
  task automatic run_vec(input vec_t v);
    int cyc;
    int first_req;
    bit got_done;
    sb.delete();
    for (int i = 0; i < v.n; i++) sb.push_back(v.codes[i]);
    @(negedge clk);
    start = 1'b1; change = v.change; empty = v.empty;
    cyc = 0; first_req = -1; got_done = 1'b0;
    while (!got_done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      start  = 1'b0;
      change = AMT_W'($urandom);   // must not disturb the transaction
      if (cyc == 1) check("busy_after_start", busy, 1);
      if (coin_req && !ack) begin
        if (first_req < 0) first_req = cyc;
        check("req_expected", sb.size() != 0, 1);
        if (sb.size() != 0) check("coin_type", coin_type, sb.pop_front());
        ack = 1'b1;
      end else if (!coin_req && ack) begin
        ack = 1'b0;
      end
      if (done) got_done = 1'b1;
    end
    check("done_seen", got_done, 1);
    if (v.n == 0) begin
      check("done_latency", cyc, 3);
      check("no_request", first_req, -1);
    end else begin
      check("first_req_latency", first_req, 3);
    end
    check("paid", paid, v.paid);
    check("residue", residue, v.residue);
    check("short", short_f, v.exp_short);
    check("coins_left", sb.size(), 0);
    check("idle_at_done", busy, 0);
    check("type_idle", coin_type, COIN_NONE);
    @(negedge clk);
    check("done_one_cycle", done, 0);
  endtask

  initial begin
    int cyc;
    int req_cycles;
    bit acked;

    vecs[0] = '{10'd85,  5'b00000, 3, {3'd0, 3'd2, 3'd3, 3'd4}, 10'd85,  10'd0,  1'b0};
    vecs[1] = '{10'd30,  5'b00100, 3, {3'd0, 3'd2, 3'd2, 3'd2}, 10'd30,  10'd0,  1'b0};
    vecs[2] = '{10'd7,   5'b00000, 1, {3'd0, 3'd0, 3'd0, 3'd1}, 10'd5,   10'd2,  1'b1};
    vecs[3] = '{10'd0,   5'b00000, 0, {3'd0, 3'd0, 3'd0, 3'd0}, 10'd0,   10'd0,  1'b0};
    vecs[4] = '{10'd65,  5'b01000, 4, {3'd1, 3'd2, 3'd3, 3'd3}, 10'd65,  10'd0,  1'b0};
    vecs[5] = '{10'd40,  5'b11111, 0, {3'd0, 3'd0, 3'd0, 3'd0}, 10'd0,   10'd40, 1'b1};
    vecs[6] = '{10'd100, 5'b00000, 1, {3'd0, 3'd0, 3'd0, 3'd5}, 10'd100, 10'd0,  1'b0};

    rst_n = 1'b0; start = 1'b0; change = '0; empty = '0; ack = 1'b0; clear = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_req", coin_req, 0);
    check("rst_type", coin_type, 0);
    check("rst_paid", paid, 0);
    check("rst_residue", residue, 0);
    check("rst_done", done, 0);
    check("rst_short", short_f, 0);
    check("rst_fault", fault, 0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Ack timeout: first coin (50) acked, second (10) never acked.
    @(negedge clk);
    start = 1'b1; change = 10'd60; empty = 5'b00000;
    cyc = 0; acked = 1'b0; req_cycles = 0;
    while (!fault && cyc < 100) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (coin_req && !acked && !ack) begin
        check("fault_first_type", coin_type, COIN_4);
        ack = 1'b1; acked = 1'b1;
      end else if (!coin_req && ack) begin
        ack = 1'b0;
      end else if (coin_req && acked) begin
        req_cycles++;
        if (req_cycles == 1) check("fault_second_type", coin_type, COIN_2);
      end
    end
    check("fault_raised", fault, 1);
    check("fault_req_high_cycles", req_cycles, 7);
    check("fault_req_dropped", coin_req, 0);
    check("fault_type_zero", coin_type, 0);
    check("fault_busy", busy, 1);
    check("fault_paid", paid, 50);
    start = 1'b1;   // ignored while busy
    repeat (3) @(negedge clk);
    start = 1'b0;
    check("fault_sticky", fault, 1);
    check("fault_still_busy", busy, 1);
    check("fault_paid_kept", paid, 50);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clear_fault", fault, 0);
    check("clear_idle", busy, 0);
    check("clear_paid_kept", paid, 50);

    // Asynchronous reset in the middle of the second REQ of a 150 payout.
    @(negedge clk);
    start = 1'b1; change = 10'd150; empty = 5'b00000;
    cyc = 0; acked = 1'b0; req_cycles = 0;
    while (req_cycles == 0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (coin_req && !acked && !ack) begin
        ack = 1'b1; acked = 1'b1;
      end else if (!coin_req && ack) begin
        ack = 1'b0;
      end else if (coin_req && acked) begin
        req_cycles = 1;
      end
    end
    check("rst_seq_second_req", req_cycles, 1);
    check("rst_seq_paid_before", paid, 100);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_req", coin_req, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_paid", paid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(vecs[6]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Payout end of the vending machine's coin path. The coin path's input end accepts inserted coins and computes a change value; this block pays that value back out. On a start strobe it latches the amount and issues one coin request at a time to the coin hopper, greedy largest-first, skipping empty tubes. It reports the amount paid, any unpayable residue, and hopper faults to the top level.

## Interface
- COIN_V1, default 10'd5: value of coin code 1
- COIN_V2, default 10'd10: value of coin code 2
- COIN_V3, default 10'd25: value of coin code 3
- COIN_V4, default 10'd50: value of coin code 4
- COIN_V5, default 10'd100: value of coin code 5
- ACK_TIMEOUT, default 32'd1000000: maximum number of i_clk cycles to wait for hopper ack before faulting
- i_clk, input, 1: clock
- i_rst_n, input, 1: asynchronous, active-low reset
- i_start, input, 1: level-sampled start; honoured only in IDLE
- i_change, input, 10: amount to pay out; sampled with i_start
- i_hopper_empty, input, 5: bit k-1 set means coin code k is unavailable
- i_coin_ack, input, 1: hopper has ejected the requested coin (4-phase)
- i_clear, input, 1: leave FAULT
- o_busy, output, 1: high in every state except IDLE
- o_coin_req, output, 1: coin request to the hopper
- o_coin_type, output, 3: coin code 1..5 while o_coin_req is high, else 0
- o_paid, output, 10: running total ejected this transaction
- o_residue, output, 10: unpaid remainder; valid from o_done until the next start
- o_done, output, 1: one-cycle pulse at end of payout
- o_short, output, 1: residue is nonzero; held until the next start
- o_fault, output, 1: ack timeout; sticky until i_clear

## Operation
- All outputs are registered. Reset value of every output is 0. Reset is asynchronous and returns the block to IDLE from any state.
- IDLE, on i_start=1:
  - r_remain <= i_change
  - o_paid <= 0, o_short <= 0, o_residue <= 0
  - next state SELECT
- SELECT (exactly 1 cycle):
  - If r_remain==0, go to DONE.
  - Otherwise pick the highest code k with COIN_Vk <= r_remain and i_hopper_empty[k-1]=0. If one is found, latch it and go to REQ. If none is found, go to DONE.
- REQ:
  - o_coin_req=1 and o_coin_type=k are held stable.
  - On i_coin_ack=1: r_remain -= COIN_Vk, o_paid += COIN_Vk, drop the request, go to RELEASE.
  - The timeout counter resets on entry to REQ. When it reaches ACK_TIMEOUT without an ack, go to FAULT.
- RELEASE: wait for i_coin_ack=0, then go to SELECT. Hopper empty flags are re-evaluated for every coin.
- DONE (1 cycle):
  - o_done=1
  - o_residue <= r_remain
  - o_short <= (r_remain != 0)
  - next state IDLE
- FAULT:
  - o_fault=1, o_coin_req=0, o_busy=1
  - On i_clear=1, go to IDLE. o_paid is kept for diagnosis.
- Arithmetic is 10-bit unsigned. A subtraction can never underflow because SELECT guarantees COIN_Vk <= r_remain.
- i_start while busy is ignored. i_change changing mid-transaction has no effect.

## Timing
- i_start is sampled at edge N. SELECT runs at N+1. o_coin_req is high after edge N+2.
- i_coin_ack is sampled at edge M. o_coin_req and o_coin_type drop after M. o_paid updates after M.
- i_coin_ack low is sampled at edge R. SELECT runs at R+1, and the next request is high after R+2. The minimum per-coin period is 4 cycles given a 1-cycle ack.
- If i_change=0, o_done pulses 2 cycles after start is sampled, with no request issued.
- The timeout fires on the ACK_TIMEOUT-th consecutive REQ cycle without an ack.

## Structure
- Shared package vm_pkg holds:
  - coin code constants COIN_NONE=0 .. COIN_5=5
  - AMT_W=10
  - state encodings IDLE, SELECT, REQ, RELEASE, DONE, FAULT
- Sub-module coin_select: combinational priority picker. Inputs are remain and hopper_empty; outputs are the code and a found flag. It is the block's only sub-module and is reused by the change-preview logic.

## Test plan
- Change 85, all tubes full, 1-cycle acks: codes 4, 3, 2 in that order; o_paid=85; o_done pulses; o_short=0, o_residue=0.
- Change 30 with i_hopper_empty=5'b00100 (code 3, the 25, empty): codes 2, 2, 2; o_paid=30; o_short=0.
- Change 7: code 1 once; o_paid=5, o_residue=2, o_short=1.
- Change 0: o_done 2 cycles after start; o_coin_req never rises.
- ACK_TIMEOUT=8 with ack withheld: o_fault rises after 8 REQ cycles and o_coin_req drops. i_clear returns to IDLE, o_busy=0.
- Reset asserted mid-REQ: o_coin_req, o_busy and o_paid are 0 immediately (asynchronous). A later start of 100 pays a single code 5.
